ext_gcd: RTL and testbench

//  Iterative extended-Euclid engine: computes gcd(a,b) and, when gcd==1, the modular inverse of
//  min(a,b) modulo max(a,b). Successor to the plain GCD block, used by RSA key setup (d = e^-1 mod phi).

---
 rtl/ext_gcd_pkg.sv | 17 +
 rtl/ext_gcd_if.sv | 20 ++
 rtl/divide.sv | 56 +++++
 rtl/ext_gcd.sv | 156 +++++++++++++++
 tb/tb_ext_gcd.sv | 139 +++++++++++++
 5 files changed

// File: rtl/ext_gcd_pkg.sv
// Shared types for the extended-Euclid engine: FSM state encoding and coefficient width helper.
package ext_gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DIV  = 3'd2,
    ST_UPD  = 3'd3,
    ST_FIX  = 3'd4
  } state_t;

  // Bezout coefficients are bounded by the modulus, so one extra sign bit suffices.
  function automatic int coef_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/ext_gcd_if.sv
// Request/result bundle of ext_gcd. iter_cnt exists only when EXT_GCD_ITER_CNT_EN is defined.
interface ext_gcd_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             finish;
  logic [WIDTH-1:0] gcd;
  logic [WIDTH-1:0] inv;
  logic             inv_ok;
`ifdef EXT_GCD_ITER_CNT_EN
  logic [WIDTH-1:0] iter_cnt;

  modport master (output start, a, b, input busy, finish, gcd, inv, inv_ok, iter_cnt);
  modport slave  (input start, a, b, output busy, finish, gcd, inv, inv_ok, iter_cnt);
`else
  modport master (output start, a, b, input busy, finish, gcd, inv, inv_ok);
  modport slave  (input start, a, b, output busy, finish, gcd, inv, inv_ok);
`endif
endinterface

// File: rtl/divide.sv
// Serial restoring unsigned divider: one quotient bit per cycle, finish pulses WIDTH+1 cycles after start.
module Divide #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_reg, rem_reg, dsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg, finish_reg;
  logic [WIDTH:0]   trial, diff;

  // Borrow out of the trial subtraction (diff MSB) means the quotient bit is 0.
  assign trial = {rem_reg, quo_reg[WIDTH-1]};
  assign diff  = trial - {1'b0, dsr_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      finish_reg <= 1'b0;
    end else begin
      finish_reg <= 1'b0;
      if (active_reg) begin
        quo_reg <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
        rem_reg <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          active_reg <= 1'b0;
          finish_reg <= 1'b1;
        end
      end else if (start) begin
        quo_reg    <= dividend;
        rem_reg    <= '0;
        dsr_reg    <= divisor;
        cnt_reg    <= CNT_W'(WIDTH);
        active_reg <= 1'b1;
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign finish    = finish_reg;
endmodule

// File: rtl/ext_gcd.sv
// Iterative extended Euclid: gcd(a,b) and min^-1 mod max, one Divide call per step.
// Optional divide counter output enabled by EXT_GCD_ITER_CNT_EN.
module ext_gcd
  import ext_gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  ext_gcd_if.slave   bus
);
  localparam int COEF_W = coef_w(WIDTH);
  localparam int PROD_W = 2 * WIDTH + 2;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]         r0_reg, r1_reg, m_reg, gcd_val_reg;
  logic signed [COEF_W-1:0] t0_reg, t1_reg, t_fin_reg;
  logic [WIDTH-1:0]         gcd_reg, inv_reg;
  logic                     inv_ok_reg, finish_reg, div_sent_reg;
  logic                     busy, div_start, div_finish, rst_n;
  logic [WIDTH-1:0]         div_quo, div_rem, max_op, min_op, inv_calc;
  logic signed [PROD_W-1:0] q_ext, t1_ext, prod;
  logic signed [COEF_W-1:0] t_new, t_wrap;

  assign max_op = (r0_reg >= r1_reg) ? r0_reg : r1_reg;
  assign min_op = (r0_reg >= r1_reg) ? r1_reg : r0_reg;

  // Only the low COEF_W product bits matter: |t| never exceeds the modulus.
  assign q_ext  = {{(WIDTH + 2){1'b0}}, div_quo};
  assign t1_ext = {{(WIDTH + 1){t1_reg[COEF_W-1]}}, t1_reg};
  assign prod   = q_ext * t1_ext;
  assign t_new  = t0_reg - $signed(prod[COEF_W-1:0]);

  // A coefficient equal to the modulus (only when m==1) reduces to 0.
  assign t_wrap   = t_fin_reg[COEF_W-1] ? (t_fin_reg + $signed({1'b0, m_reg})) : t_fin_reg;
  assign inv_calc = (t_wrap[WIDTH-1:0] == m_reg) ? '0 : t_wrap[WIDTH-1:0];

  assign rst_n = ~rst;

  Divide #(.WIDTH(WIDTH)) u_divide (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (r0_reg),
    .divisor   (r1_reg),
    .quotient  (div_quo),
    .remainder (div_rem),
    .finish    (div_finish)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_LOAD;
      ST_LOAD: state_next = (min_op == '0) ? ST_FIX : ST_DIV;
      ST_DIV:  if (div_finish) state_next = (div_rem != '0) ? ST_UPD : ST_FIX;
      ST_UPD:  state_next = ST_DIV;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE) || finish_reg;
    div_start = (state_reg == ST_DIV) && !div_sent_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_reg       <= '0;
      r1_reg       <= '0;
      m_reg        <= '0;
      t0_reg       <= '0;
      t1_reg       <= '0;
      t_fin_reg    <= '0;
      gcd_val_reg  <= '0;
      gcd_reg      <= '0;
      inv_reg      <= '0;
      inv_ok_reg   <= 1'b0;
      finish_reg   <= 1'b0;
      div_sent_reg <= 1'b0;
    end else begin
      finish_reg   <= (state_reg == ST_FIX);
      div_sent_reg <= (state_reg == ST_DIV) && (state_next == ST_DIV);
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            r0_reg <= bus.a;
            r1_reg <= bus.b;
          end
        end
        ST_LOAD: begin
          r0_reg <= max_op;
          r1_reg <= min_op;
          m_reg  <= max_op;
          t0_reg <= '0;
          t1_reg <= COEF_W'(1);
          if (min_op == '0) begin
            gcd_val_reg <= max_op;
            t_fin_reg   <= '0;
          end
        end
        ST_DIV: begin
          if (div_finish && (div_rem == '0)) begin
            gcd_val_reg <= r1_reg;
            t_fin_reg   <= t1_reg;
          end
        end
        ST_UPD: begin
          t0_reg <= t1_reg;
          t1_reg <= t_new;
          r0_reg <= r1_reg;
          r1_reg <= div_rem;
        end
        ST_FIX: begin
          gcd_reg    <= gcd_val_reg;
          inv_ok_reg <= (gcd_val_reg == WIDTH'(1));
          inv_reg    <= (gcd_val_reg == WIDTH'(1)) ? inv_calc : '0;
        end
        default: ;
      endcase
    end
  end

`ifdef EXT_GCD_ITER_CNT_EN
  logic [WIDTH-1:0] iter_reg, iter_out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_reg     <= '0;
      iter_out_reg <= '0;
    end else begin
      if (state_reg == ST_LOAD)
        iter_reg <= '0;
      else if (div_start && (iter_reg != '1))
        iter_reg <= iter_reg + WIDTH'(1);
      if (state_reg == ST_FIX)
        iter_out_reg <= iter_reg;
    end
  end

  assign bus.iter_cnt = iter_out_reg;
`endif

  assign bus.busy   = busy;
  assign bus.finish = finish_reg;
  assign bus.gcd    = gcd_reg;
  assign bus.inv    = inv_reg;
  assign bus.inv_ok = inv_ok_reg;
endmodule

// File: tb/tb_ext_gcd.sv
// Directed-vector bench for ext_gcd; iter_cnt is also checked when EXT_GCD_ITER_CNT_EN is defined.
module tb_ext_gcd;
  localparam int WIDTH   = 8;
  // Divide reports finish WIDTH+1 cycles after its start cycle.
  localparam int DIV_LAT = WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   div_cnt = 0;

  ext_gcd_if #(.WIDTH(WIDTH)) bus ();

  ext_gcd #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.div_start === 1'b1) div_cnt <= div_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int exp_gcd, input int exp_inv, input int exp_ok,
                         input int exp_divs, input int extra_at);
    int cycles;
    int base;
    int exp_lat;
    bit got;
    cycles = 0;
    got    = 1'b0;
    exp_lat = (exp_divs == 0) ? 3 : 3 + exp_divs * (DIV_LAT + 1) + (exp_divs - 1);
    @(negedge clk);
    base      = div_cnt;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    while (cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
      end
      if (extra_at != 0 && cycles == extra_at) begin
        bus.a     = 8'd9;
        bus.b     = 8'd4;
        bus.start = 1'b1;
      end
      if (extra_at != 0 && cycles == extra_at + 1) bus.start = 1'b0;
      if (bus.finish === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("finish_seen", 32'(got), 32'd1);
    check("gcd", 32'(bus.gcd), 32'(exp_gcd));
    check("inv", 32'(bus.inv), 32'(exp_inv));
    check("inv_ok", 32'(bus.inv_ok), 32'(exp_ok));
    check("divides", 32'(div_cnt - base), 32'(exp_divs));
    check("latency", 32'(cycles), 32'(exp_lat));
    check("busy_at_finish", 32'(bus.busy), 32'd1);
`ifdef EXT_GCD_ITER_CNT_EN
    check("iter_cnt", 32'(bus.iter_cnt), 32'(exp_divs));
`endif
    $display("vec a=%0d b=%0d -> gcd=%0d inv=%0d inv_ok=%0d divides=%0d cycles=%0d",
             a, b, bus.gcd, bus.inv, bus.inv_ok, div_cnt - base, cycles);
    @(negedge clk);
    check("finish_one_cycle", 32'(bus.finish), 32'd0);
    check("busy_dropped", 32'(bus.busy), 32'd0);
    check("gcd_held", 32'(bus.gcd), 32'(exp_gcd));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_gcd", 32'(bus.gcd), 32'd0);
    check("rst_inv", 32'(bus.inv), 32'd0);
    check("rst_inv_ok", 32'(bus.inv_ok), 32'd0);
    rst = 1'b0;

    run_vec(8'd40,  8'd7,   1,  23,  1, 4, 0);
    run_vec(8'd7,   8'd40,  1,  23,  1, 4, 0);
    run_vec(8'd240, 8'd46,  2,  0,   0, 5, 0);
    run_vec(8'd15,  8'd0,   15, 0,   0, 0, 0);
    run_vec(8'd0,   8'd0,   0,  0,   0, 0, 0);
    run_vec(8'd17,  8'd5,   1,  7,   1, 3, 0);
    run_vec(8'd1,   8'd1,   1,  0,   1, 1, 0);
    run_vec(8'd1,   8'd0,   1,  0,   1, 0, 0);
    run_vec(8'd13,  8'd13,  13, 0,   0, 1, 0);
    run_vec(8'd255, 8'd254, 1,  254, 1, 2, 0);
    run_vec(8'd40,  8'd7,   1,  23,  1, 4, 5);

    // Reset while the engine sits in DIV; outputs must clear without waiting for a clock.
    @(negedge clk);
    bus.a     = 8'd240;
    bus.b     = 8'd46;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_finish", 32'(bus.finish), 32'd0);
    check("midrst_gcd", 32'(bus.gcd), 32'd0);
    check("midrst_inv", 32'(bus.inv), 32'd0);
    check("midrst_inv_ok", 32'(bus.inv_ok), 32'd0);
    check("midrst_div_start", 32'(dut.div_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(8'd17, 8'd5, 1, 7, 1, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
